apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
- APB3 completer that sits directly downstream of the team's APB master and terminates its transfers.
- Contains a bank of 32-bit registers, inserts a programmable number of wait states, and flags illegal accesses with pslverr.
- Provides the master with pready/prdata/pslverr and exposes register contents to the surrounding logic.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, range 2..256.
- WAIT_CYCLES, 1, wait states inserted in every access phase; 0 means zero-wait.
- ID_VALUE, 32'hA5B0_0001, read-only content of register 0.

Ports:
- pclk  input  1  the block's one clock; all state updates on its rising edge.
- preset  input  1  reset: asynchronous and active-high.
- psel  input  1  slave select from the master.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid while pready is high.
- pready  output  1  transfer completion.
- pslverr  output  1  error response, valid only while pready is high.
- regs_flat  output  NUM_REGS*32  register contents; register i occupies bits [32*i+31:32*i].

Behaviour:
- Reset (async, preset=1):
  - Registers 1..NUM_REGS-1 are cleared to 0.
  - prdata = 0; wait counter = 0; FSM = IDLE.
  - pready and pslverr drop to 0 immediately, with no clock edge needed.
  - A transfer in flight when reset is applied is abandoned and no write commits.
- Address decode:
  - idx = paddr[$clog2(NUM_REGS)+1:2].
  - err = (paddr[1:0] != 0) | (paddr >= 4*NUM_REGS) | (pwrite & idx == 0).
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next edge.
  - ACCESS -> IDLE on the edge where pready=1.
  - Any state -> IDLE if psel=0.
  - psel=1 and penable=1 while in IDLE is a protocol violation: treat it as ACCESS with err forced to 1.
- Setup edge (psel=1, penable=0):
  - prdata loads reg[idx], or 0 if err.
  - Register 0 always returns ID_VALUE.
  - The wait counter clears to 0.
- Access phase:
  - The counter increments each cycle while psel & penable & counter < WAIT_CYCLES.
  - pready = psel & penable & (counter == WAIT_CYCLES), combinational from the counter.
  - With WAIT_CYCLES=0, pready is high in the first access cycle.
  - Transfer latency is WAIT_CYCLES+1 access cycles.
- Response:
  - pslverr = pready & err; 0 at all other times.
- Write commit:
  - reg[idx] <= pwdata on the rising edge where psel & penable & pready & pwrite & !err.
  - No partial writes. An erroring write leaves every register unchanged.
- Back-to-back transfers: a new setup phase may follow the completion cycle directly. The counter restarts at 0 and no idle cycle is required.
- prdata holds its last value between transfers. Nothing downstream relies on it outside pready.
- If inputs change mid-access (paddr or pwrite), the values sampled at the completion edge govern the commit. The master is required to hold them stable.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS).
  - APB data/address width constants (32).
  - Default ID_VALUE.
- One natural sub-module: apb_wait_counter.
  - Inputs: clear, enable.
  - Outputs: done; saturating count up to WAIT_CYCLES.
- The register array and decode stay in the top module.

Test Plan:
- Reset, then read 0x00 and 0x04 (WAIT_CYCLES=1) -> prdata=32'hA5B0_0001 then 0, pready on the 2nd access cycle, pslverr=0.
- Write 0xDEADBEEF to 0x08, read it back -> prdata=32'hDEADBEEF; regs_flat[95:64]=32'hDEADBEEF from the edge after the write completes.
- Write to 0x00, write to 0x41 (misaligned), read 0x40 (NUM_REGS=16) -> pslverr=1 with pready on all three; read returns 0; no register changes.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds, back-to-back write/read to 0x0C -> pready on access cycle 1 and 4 respectively; read returns the just-written data.
- Assert preset mid-ACCESS of a write to 0x10 while the counter is at 1 -> pready=0 immediately; reg[4] stays 0; the next transfer completes normally.
- psel=1 with penable=1 and no setup phase -> transfer completes with pslverr=1; no write commits.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions for the register-file completer: bus widths, the
// default identification word, the transfer FSM state type and a helper that
// sizes the wait-state counter.
// No ports (package).
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int unsigned APB_DW = 32;
   localparam int unsigned APB_AW = 32;

   localparam logic [APB_DW-1:0] DEFAULT_ID = 32'hA5B0_0001;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } apb_state_e;

   // Counter width able to hold max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// ---------------------------------------------------------------------------
// apb_wait_counter
// Saturating wait-state counter for the APB access phase.
// Ports:
//   pclk      clock, rising edge
//   preset    asynchronous active-high reset, count -> 0
//   i_clear   synchronous clear (setup phase), wins over i_enable
//   i_enable  count up by one, stops at MAX_COUNT
//   o_done    count has reached MAX_COUNT
//   o_count   current count
// ---------------------------------------------------------------------------
module apb_wait_counter
   import apb_pkg::*;
#(
   parameter  int unsigned MAX_COUNT = 1,
   localparam int unsigned CW        = cnt_width(MAX_COUNT)
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic          i_clear,
   input  logic          i_enable,
   output logic          o_done,
   output logic [CW-1:0] o_count
);

   logic [CW-1:0] r_cnt;

   assign o_done  = (r_cnt == CW'(MAX_COUNT));
   assign o_count = r_cnt;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_done) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// APB3 completer holding NUM_REGS 32-bit registers. Register 0 is a read-only
// ID word; every access phase is stretched by WAIT_CYCLES wait states;
// misaligned, out-of-range and register-0 writes answer with pslverr.
// Ports:
//   pclk, preset          clock / asynchronous active-high reset
//   psel, penable,
//   pwrite, paddr, pwdata APB request from the master
//   prdata, pready,
//   pslverr               APB response (prdata/pslverr valid with pready)
//   regs_flat             register contents, reg i at [32*i+31:32*i]
// ---------------------------------------------------------------------------
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned        NUM_REGS    = 16,
   parameter int unsigned        WAIT_CYCLES = 1,
   parameter logic [APB_DW-1:0]  ID_VALUE    = DEFAULT_ID
) (
   input  logic                   pclk,
   input  logic                   preset,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [APB_AW-1:0]      paddr,
   input  logic [APB_DW-1:0]      pwdata,
   output logic [APB_DW-1:0]      prdata,
   output logic                   pready,
   output logic                   pslverr,
   output logic [NUM_REGS*32-1:0] regs_flat
);

   localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
   localparam int unsigned       CNT_W      = cnt_width(WAIT_CYCLES);
   localparam logic [APB_AW-1:0] ADDR_LIMIT = APB_AW'(4 * NUM_REGS);

   apb_state_e        r_state, w_state_next;
   logic              r_viol, w_viol_next;
   logic [IDX_W-1:0]  w_idx;
   logic              w_setup, w_access, w_dec_err, w_err, w_done, w_we;
   logic [CNT_W-1:0]  w_count;
   logic [APB_DW-1:0] w_regs [NUM_REGS];
   logic [APB_DW-1:0] r_prdata;

   assign w_setup  = psel & ~penable;
   assign w_access = psel & penable;

   assign w_idx     = paddr[IDX_W+1:2];
   assign w_dec_err = (paddr[1:0] != 2'b00) | (paddr >= ADDR_LIMIT) |
                      (pwrite & (w_idx == '0));
   // An access phase that arrives without a setup phase (in IDLE, or in the
   // ACCESS state entered that way) always answers with an error.
   assign w_err     = w_dec_err | r_viol | (w_access & (r_state == StIdle));

   apb_wait_counter #(
      .MAX_COUNT (WAIT_CYCLES)
   ) u_wait_counter (
      .pclk     (pclk),
      .preset   (preset),
      .i_clear  (w_setup),
      .i_enable (w_access & (w_count < CNT_W'(WAIT_CYCLES))),
      .o_done   (w_done),
      .o_count  (w_count)
   );

   // Gated by preset so the response drops the moment reset is applied.
   assign pready  = w_access & w_done & ~preset;
   assign pslverr = pready & w_err;
   assign prdata  = r_prdata;
   assign w_we    = pready & pwrite & ~w_err;

   always_comb begin
      w_state_next = r_state;
      w_viol_next  = r_viol;
      if (!psel) begin
         w_state_next = StIdle;
         w_viol_next  = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (!penable) begin
                  w_state_next = StSetup;
               end else if (!pready) begin
                  w_state_next = StAccess;
                  w_viol_next  = 1'b1;
               end
            end
            StSetup: begin
               w_state_next = StAccess;
               w_viol_next  = 1'b0;
            end
            StAccess: begin
               if (pready) begin
                  w_state_next = StIdle;
                  w_viol_next  = 1'b0;
               end
            end
            default: begin
               w_state_next = StIdle;
               w_viol_next  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state  <= StIdle;
         r_viol   <= 1'b0;
         r_prdata <= '0;
      end else begin
         r_state <= w_state_next;
         r_viol  <= w_viol_next;
         if (w_setup) begin
            r_prdata <= w_dec_err ? '0 : w_regs[w_idx];
         end
      end
   end

   assign w_regs[0]      = ID_VALUE;
   assign regs_flat[31:0] = ID_VALUE;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [APB_DW-1:0] r_reg;

      always_ff @(posedge pclk or posedge preset) begin
         if (preset) begin
            r_reg <= '0;
         end else if (w_we && (w_idx == IDX_W'(gi))) begin
            r_reg <= pwdata;
         end
      end

      assign w_regs[gi]            = r_reg;
      assign regs_flat[32*gi +: 32] = r_reg;
   end

endmodule
